rgb_pwm_fader: RTL
==================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12, meaning clk_in cycles per PWM tick (range 1..65535).
REQ-002 SHALL have parameter FADE_EN, default 1, meaning 1 = ramp duty toward target, 0 = jump to target.
REQ-003 SHALL have port clk_in  input  1  meaning the single 12 MHz clock; all logic runs in this one clock domain.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  meaning a new colour command is present.
REQ-006 SHALL have port cmd_ready  output  1  meaning the block can accept a command.
REQ-007 SHALL have port cmd_rgb  input  24  meaning the target duty per channel: [23:16] red, [15:8] green, [7:0] blue.
REQ-008 SHALL have port rgb  output  3  meaning the active-low LED drives: [0] red, [1] green, [2] blue.
REQ-009 SHALL have port period_end  output  1  meaning a one-cycle pulse on the last tick of each PWM period.

Function
REQ-010 SHALL generate a tick every CLK_DIV clk_in cycles from a prescaler counting 0..CLK_DIV-1, with the tick asserted when the count equals CLK_DIV-1.
REQ-011 SHALL advance an 8-bit pwm_cnt by 1 on each tick and wrap it from 255 to 0.
REQ-012 SHALL make one PWM period exactly 256 ticks (256*CLK_DIV cycles).
REQ-013 SHALL drive each channel low (LED on) exactly when pwm_cnt < duty_cur[ch], and high otherwise; the comparison is unsigned 8-bit.
REQ-014 SHALL give duty 0 an output that stays high for the whole period, and duty 255 an output that is low for 255 of 256 ticks.
REQ-015 SHALL register rgb, so rgb changes one clk_in cycle after pwm_cnt changes.
REQ-016 SHALL assert period_end for one cycle when the tick occurs while pwm_cnt = 255.
REQ-017 SHALL implement a state machine with two states, IDLE and UPDATE.
REQ-018 SHALL assert cmd_ready exactly when the state is IDLE.
REQ-019 SHALL, on cmd_valid && cmd_ready, latch cmd_rgb into duty_tgt and move to UPDATE.
REQ-020 SHALL ignore cmd_valid while in UPDATE, with no latching and no error.
REQ-021 SHALL, in UPDATE on each period_end with FADE_EN=1, move every channel with duty_cur != duty_tgt one step (+1 or -1) toward duty_tgt; equal channels hold.
REQ-022 SHALL, in UPDATE on the first period_end with FADE_EN=0, load duty_cur with duty_tgt.
REQ-023 SHALL return from UPDATE to IDLE on the period_end at which the updated duty_cur equals duty_tgt on all channels.
REQ-024 SHALL treat a command equal to duty_cur as going to UPDATE and returning to IDLE at the next period_end.
REQ-025 SHALL never change duty_cur except at period_end, so no period is ever truncated.
REQ-026 SHALL, when a command is accepted in the same cycle as period_end, take effect from the following period_end.
REQ-027 SHALL keep duty_cur from wrapping: steps stop at the target, so 0 minus 1 and 255 plus 1 never occur.

Reset
REQ-028 SHALL, while rst=1, clear the prescaler, pwm_cnt, duty_cur and duty_tgt to 0, set the state to IDLE, set rgb to 3'b111 (all LEDs off) and set period_end to 0.
REQ-029 SHALL, on rst during UPDATE, abandon the fade and leave no pending target.
REQ-030 SHALL raise cmd_ready in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the PWM_W=8 width constant, the channel index constants (RED=0, GREEN=1, BLUE=2) and the state encoding in shared package rgb_pkg.
REQ-032 SHALL use one sub-module, rgb_pwm_chan, instantiated three times, containing duty_cur, the step-toward-target logic and the compare/output register; the prescaler, pwm_cnt and state machine stay in the top module.

Verification
REQ-033 SHALL cover reset: with CLK_DIV=2 and rst held then released, rgb=3'b111, cmd_ready=1 and period_end first pulses 512 cycles after rst deasserts.
REQ-034 SHALL cover a jump: with FADE_EN=0 and cmd_rgb=24'h80_00_FF, from the next period_end red is low for 128 ticks, green stays high, blue is low for 255 ticks, and cmd_ready returns to 1.
REQ-035 SHALL cover a fade: with FADE_EN=1, starting from duty 0, cmd_rgb=24'h03_00_00 gives red duty 1, 2, 3 at successive period_ends, and cmd_ready rises at the third.
REQ-036 SHALL cover fade-down and busy: from red=5, cmd 0 gives 5 steps down, and a second cmd_valid pulsed during UPDATE is ignored (duty_tgt unchanged).
REQ-037 SHALL cover reset mid-fade: rst asserted while red ramps 0 to 200 gives rgb=3'b111 immediately and duty_cur=0 with IDLE after release.
REQ-038 SHALL cover simultaneity: a command accepted in the period_end cycle leaves the current period's duty unchanged and first changes duty at the next period_end.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB PWM fader: channel width,
// channel indices and the command FSM state encoding.
package rgb_pkg;
    localparam int PWM_W = 8;

    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int BLUE  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } fsm_state_t;
endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Colour command channel of the RGB PWM fader.
// A command transfers on a clk_in edge where cmd_valid and cmd_ready are both
// high; cmd_rgb must be stable while cmd_valid is high. Red is [23:16], green [15:8], blue [7:0].
interface rgb_pwm_fader_if;
    import rgb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3*PWM_W-1:0]   cmd_rgb;

    modport master (output cmd_valid, output cmd_rgb, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rgb, output cmd_ready);
endinterface

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: current duty, one-step move toward the target, and the
// registered active-low compare output.
module rgb_pwm_chan
    import rgb_pkg::*;
#(
    parameter int unsigned FADE_EN = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             step,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] duty_tgt,
    output logic             led_n,
    output logic             at_tgt_nxt
);
    logic [PWM_W-1:0] duty_cur;
    logic [PWM_W-1:0] duty_nxt;

    // The strict compares stop the ramp at the target, so duty never wraps.
    always_comb begin
        duty_nxt = duty_cur;
        if (FADE_EN == 0) begin
            duty_nxt = duty_tgt;
        end else if (duty_cur < duty_tgt) begin
            duty_nxt = duty_cur + PWM_W'(1);
        end else if (duty_cur > duty_tgt) begin
            duty_nxt = duty_cur - PWM_W'(1);
        end
    end

    assign at_tgt_nxt = (duty_nxt == duty_tgt);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty_cur <= '0;
        end else if (step) begin
            duty_cur <= duty_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            led_n <= 1'b1;
        end else begin
            led_n <= !(pwm_cnt < duty_cur);
        end
    end
endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED PWM driver: prescaler, 8-bit PWM counter, and a command FSM that
// moves the three channel duties to a new colour only at period boundaries.
module rgb_pwm_fader
    import rgb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12,
    parameter int unsigned FADE_EN = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    rgb_pwm_fader_if.slave   cmd,
    output logic [2:0]       rgb,
    output logic             period_end,
    output fsm_state_t       state_dbg
);
    logic [15:0]          presc;
    logic                 tick;
    logic                 wrap;
    logic [PWM_W-1:0]     pwm_cnt;
    logic [3*PWM_W-1:0]   duty_tgt;
    logic [2:0]           at_tgt;
    logic                 step;
    fsm_state_t           state;
    fsm_state_t           state_nxt;

    assign tick = (presc == 16'(CLK_DIV - 1));
    assign wrap = tick && (pwm_cnt == {PWM_W{1'b1}});

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            pwm_cnt    <= '0;
            period_end <= 1'b0;
        end else begin
            presc      <= tick ? 16'd0 : presc + 16'd1;
            period_end <= wrap;
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty_tgt <= '0;
        end else if (state == IDLE && cmd.cmd_valid) begin
            duty_tgt <= cmd.cmd_rgb;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Duties move on the wrap edge, together with pwm_cnt returning to 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd.cmd_valid) state_nxt = UPDATE;
            UPDATE:  if (wrap && (&at_tgt)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == IDLE);
        step          = wrap && (state == UPDATE);
        state_dbg     = state;
    end

    rgb_pwm_chan #(.FADE_EN(FADE_EN)) u_red (
        .clk_in     (clk_in),
        .rst        (rst),
        .step       (step),
        .pwm_cnt    (pwm_cnt),
        .duty_tgt   (duty_tgt[3*PWM_W-1:2*PWM_W]),
        .led_n      (rgb[RED]),
        .at_tgt_nxt (at_tgt[RED])
    );

    rgb_pwm_chan #(.FADE_EN(FADE_EN)) u_green (
        .clk_in     (clk_in),
        .rst        (rst),
        .step       (step),
        .pwm_cnt    (pwm_cnt),
        .duty_tgt   (duty_tgt[2*PWM_W-1:PWM_W]),
        .led_n      (rgb[GREEN]),
        .at_tgt_nxt (at_tgt[GREEN])
    );

    rgb_pwm_chan #(.FADE_EN(FADE_EN)) u_blue (
        .clk_in     (clk_in),
        .rst        (rst),
        .step       (step),
        .pwm_cnt    (pwm_cnt),
        .duty_tgt   (duty_tgt[PWM_W-1:0]),
        .led_n      (rgb[BLUE]),
        .at_tgt_nxt (at_tgt[BLUE])
    );
endmodule
